// File: rtl/gfx_cmd_pkg.sv
// Shared constants and FSM encoding for the G10k command front-end.
package gfx_cmd_pkg;
  localparam int CMD_W = 24;
  localparam int OP_HI = 23;
  localparam int OP_LO = 20;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GAP       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } cmd_state_e;
endpackage

// File: rtl/gfx_cmd_fifo.sv
// Synchronous FIFO with registered occupancy count and synchronous clear.
module gfx_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/gfx_cmd_queue.sv
// G10k command front-end: queues CPU words and replays them as spaced start pulses,
// stalling on blocking commands until clear-done and optionally gating on frame sync.
module gfx_cmd_queue
  import gfx_cmd_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter int         AW       = 4,
  parameter int         GAP      = 4,
  parameter logic [3:0] BLOCK_OP = 4'hF,
  parameter int         TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CMD_W-1:0] wr_data,
  output logic             full,
  output logic [AW:0]      level,
  output logic [CMD_W-1:0] cmd_out,
  output logic             cmd_start,
  input  logic             done,
  input  logic             frame,
  input  logic             sync_mode,
  input  logic             flush,
  input  logic             clr_flags,
  output logic             ovf,
  output logic             tmo,
  output logic             busy
);
  localparam int GW = $clog2(GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  cmd_state_e       state;
  logic [GW-1:0]    gap_cnt;
  logic [TW-1:0]    wait_cnt;
  logic             win;
  logic [CMD_W-1:0] head;
  logic [AW:0]      count;
  logic             push, issue, empties, ovf_evt, tmo_evt;

  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign busy    = (state != ST_IDLE) || (count != '0);
  assign push    = wr_en && !full && !flush;
  assign issue   = (state == ST_IDLE) && (count != '0) && (!sync_mode || win) && !flush;
  // A same-cycle write keeps the FIFO non-empty, so the window stays open.
  assign empties = issue && (count == (AW+1)'(1)) && !push;
  assign ovf_evt = wr_en && full && !flush;
  assign tmo_evt = (state == ST_WAIT_DONE) && !done && !flush && (wait_cnt == TW'(TIMEOUT - 1));

  gfx_cmd_fifo #(.DEPTH(DEPTH), .AW(AW), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (issue),
    .din   (wr_data),
    .dout  (head),
    .count (count)
  );

  // GAP state lasts GAP-1 edges so the next IDLE issue lands exactly GAP edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      wait_cnt  <= '0;
      cmd_out   <= '0;
      cmd_start <= 1'b0;
    end else begin
      cmd_start <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (issue) begin
            cmd_out   <= head;
            cmd_start <= 1'b1;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            state     <= (head[OP_HI:OP_LO] == BLOCK_OP) ? ST_WAIT_DONE : ST_GAP;
          end
          ST_GAP: begin
            if (gap_cnt == GW'(GAP - 2)) state <= ST_IDLE;
            else gap_cnt <= gap_cnt + 1'b1;
          end
          ST_WAIT_DONE: begin
            if (done || tmo_evt) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win <= 1'b0;
      ovf <= 1'b0;
      tmo <= 1'b0;
    end else begin
      if (flush || empties) win <= 1'b0;
      else if (frame)       win <= 1'b1;
      if (ovf_evt)        ovf <= 1'b1;
      else if (clr_flags) ovf <= 1'b0;
      if (tmo_evt)        tmo <= 1'b1;
      else if (clr_flags) tmo <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Randomized and directed bench for gfx_cmd_queue against a time-based queue model.
module tb_gfx_cmd_queue;
  localparam int DEPTH = 16;
  localparam int GAP = 4;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0, done = 1'b0, frame = 1'b0, sync_mode = 1'b0, flush = 1'b0, clr_flags = 1'b0;
  logic [23:0] wr_data = '0;
  logic full, cmd_start, ovf, tmo, busy;
  logic [4:0] level;
  logic [23:0] cmd_out;

  int errors = 0;
  int checks = 0;

  gfx_cmd_queue #(.DEPTH(DEPTH), .AW(4), .GAP(GAP), .BLOCK_OP(4'hF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .level(level),
    .cmd_out(cmd_out), .cmd_start(cmd_start), .done(done), .frame(frame),
    .sync_mode(sync_mode), .flush(flush), .clr_flags(clr_flags), .ovf(ovf), .tmo(tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  wire [33:0] dvec = {cmd_start, cmd_out, level, full, ovf, tmo, busy};

  // Model: t is the index of the next clock edge; issue allowed once t >= earliest.
  int t = 0;
  int earliest = 0;
  int ib = 0;
  bit blocking = 0, win = 0, m_ovf = 0, m_tmo = 0, m_start = 0;
  logic [23:0] m_out = '0;
  logic [23:0] q[$];

  function automatic logic [33:0] mvec();
    bit mbusy;
    mbusy = blocking || (t < earliest) || (q.size() != 0);
    return {m_start, m_out, 5'(q.size()), q.size() == DEPTH, m_ovf, m_tmo, mbusy};
  endfunction

  task automatic model_step();
    bit was_full, pushed, empties;
    logic [23:0] w;
    if (!rst) begin
      q.delete(); earliest = 0; blocking = 0; win = 0;
      m_ovf = 0; m_tmo = 0; m_start = 0; m_out = '0;
      t++;
      return;
    end
    was_full = (q.size() == DEPTH);
    m_start = 0;
    if (clr_flags) begin m_ovf = 0; m_tmo = 0; end
    if (flush) begin
      q.delete(); blocking = 0; earliest = t + 1; win = 0;
    end else begin
      empties = 0;
      pushed = wr_en && !was_full;
      if (wr_en && was_full) m_ovf = 1;
      if (blocking) begin
        if (done) begin blocking = 0; earliest = t + GAP; end
        else if (t == ib + TIMEOUT) begin blocking = 0; m_tmo = 1; earliest = t + GAP; end
      end else if (t >= earliest && q.size() > 0 && (!sync_mode || win)) begin
        w = q.pop_front();
        m_out = w; m_start = 1;
        if (w[23:20] == 4'hF) begin blocking = 1; ib = t; end
        else earliest = t + GAP;
        empties = (q.size() == 0) && !pushed;
      end
      if (pushed) q.push_back(wr_data);
      if (empties) win = 0;
      else if (frame) win = 1;
    end
    t++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    checks++;
    if (dvec !== 34'h0) begin errors++; $display("FAIL reset_state got=%h exp=0", dvec); end
    sync_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 24'(32'h100000 + i);
      tick();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL reset_fill t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd5) begin errors++; $display("FAIL reset_prefill level got=%0d exp=5", level); end
    rst = 1'b0;
    #2;
    checks++;
    if (dvec !== 34'h0) begin errors++; $display("FAIL reset_async got=%h exp=0", dvec); end
    tick();
    rst = 1'b1; sync_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_start) pulses++;
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL reset_idle t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL reset_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_spacing();
    int e0, ns;
    int st[3];
    logic [23:0] so[3];
    flush = 1'b1; tick(); flush = 1'b0;
    e0 = t; ns = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = (i < 3); wr_data = 24'(32'h100001 + i);
      tick();
      if (cmd_start && ns < 3) begin st[ns] = t - 1; so[ns] = cmd_out; ns++; end
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL spacing t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    wr_en = 1'b0;
    checks++;
    if (ns != 3) begin errors++; $display("FAIL spacing_count got=%0d exp=3", ns); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (st[i] != e0 + 1 + i * GAP || so[i] !== 24'(32'h100001 + i)) begin
        errors++;
        $display("FAIL spacing_start%0d edge got=%0d exp=%0d word got=%h", i, st[i] - e0, 1 + i * GAP, so[i]);
      end
    end
  endtask

  task automatic test_blocking();
    int s1, d, s2;
    logic [23:0] w2;
    flush = 1'b1; tick(); flush = 1'b0;
    wr_en = 1'b1; wr_data = 24'hF00000; tick();
    wr_data = 24'h200000; tick();
    wr_en = 1'b0;
    s1 = t - 1;
    checks++;
    if (cmd_start !== 1'b1 || cmd_out !== 24'hF00000) begin
      errors++; $display("FAIL block_first start=%b out=%h exp 1/f00000", cmd_start, cmd_out);
    end
    while (t < s1 + 20) begin
      tick();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL block_wait t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    done = 1'b1; tick(); done = 1'b0;
    d = t - 1; s2 = -1;
    for (int i = 0; i < 20 && s2 < 0; i++) begin
      tick();
      if (cmd_start) begin s2 = t - 1; w2 = cmd_out; end
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL block_done t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    checks++;
    if (s2 != d + GAP || w2 !== 24'h200000) begin
      errors++; $display("FAIL block_after_done delta got=%0d exp=%0d word=%h", s2 - d, GAP, w2);
    end
    repeat (GAP) tick();
    wr_en = 1'b1; wr_data = 24'hF00001; tick();
    wr_data = 24'h200001; tick();
    wr_en = 1'b0;
    s1 = t - 1; s2 = -1;
    for (int i = 0; i < TIMEOUT + 50 && s2 < 0; i++) begin
      tick();
      if (cmd_start) begin s2 = t - 1; w2 = cmd_out; end
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL block_tmo t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    checks++;
    if (s2 != s1 + TIMEOUT + GAP || tmo !== 1'b1 || w2 !== 24'h200001) begin
      errors++; $display("FAIL block_timeout delta got=%0d exp=%0d tmo=%b word=%h", s2 - s1, TIMEOUT + GAP, tmo, w2);
    end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_clear got=%b exp=0", tmo); end
  endtask

  task automatic test_full();
    int n = 0;
    bit saw17 = 0;
    flush = 1'b1; tick(); flush = 1'b0;
    sync_mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 24'(32'h300000 + i);
      tick();
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL full_fill t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    wr_en = 1'b0;
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || ovf !== 1'b1) begin
      errors++; $display("FAIL full_state full=%b level=%0d ovf=%b exp 1/16/1", full, level, ovf);
    end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    sync_mode = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (cmd_start) begin n++; if (cmd_out == 24'h300010) saw17 = 1; end
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL full_drain t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    checks++;
    if (n != 16 || saw17) begin errors++; $display("FAIL full_drain_count got=%0d exp=16 dropped_seen=%0d", n, saw17); end
  endtask

  task automatic test_frame();
    int f, ns = 0;
    int st[3];
    flush = 1'b1; tick(); flush = 1'b0;
    sync_mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      wr_en = (i < 3); wr_data = 24'(32'h600000 + i);
      tick();
      if (cmd_start) ns++;
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL frame_hold t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    wr_en = 1'b0;
    checks++;
    if (ns != 0 || level !== 5'd3) begin errors++; $display("FAIL frame_gate starts=%0d level=%0d exp 0/3", ns, level); end
    frame = 1'b1; tick(); frame = 1'b0;
    f = t - 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (cmd_start && ns < 3) begin st[ns] = t - 1; ns++; end
      checks++;
      if (dvec !== mvec()) begin errors++; $display("FAIL frame_run t=%0d got=%h exp=%h", t, dvec, mvec()); end
    end
    checks++;
    if (ns != 3 || st[0] != f + 1 || st[1] != f + 1 + GAP || st[2] != f + 1 + 2 * GAP) begin
      errors++; $display("FAIL frame_starts n=%0d exp=3 first_delta=%0d exp=1", ns, st[0] - f);
    end
    ns = 0;
    wr_en = 1'b1; wr_data = 24'h600003; tick(); wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_start) ns++;
    end
    checks++;
    if (ns != 0) begin errors++; $display("FAIL frame_closed starts=%0d exp=0", ns); end
    frame = 1'b1; tick(); frame = 1'b0;
    tick();
    checks++;
    if (cmd_start !== 1'b1 || cmd_out !== 24'h600003) begin
      errors++; $display("FAIL frame_reopen start=%b out=%h exp 1/600003", cmd_start, cmd_out);
    end
    sync_mode = 1'b0;
    repeat (GAP) tick();
  endtask

  task automatic test_flush();
    int ns = 0;
    flush = 1'b1; tick(); flush = 1'b0;
    wr_en = 1'b1; wr_data = 24'hF00002; tick();
    for (int i = 0; i < 4; i++) begin wr_data = 24'(32'h400001 + i); tick(); end
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd4 || !busy) begin errors++; $display("FAIL flush_pre level=%0d busy=%b exp 4/1", level, busy); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 24'h777777; tick(); flush = 1'b0; wr_en = 1'b0;
    checks++;
    if (level !== 5'd0 || busy !== 1'b0 || cmd_out !== 24'hF00002 || cmd_start !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL flush_state level=%0d busy=%b out=%h ovf=%b exp 0/0/f00002/0", level, busy, cmd_out, ovf);
    end
    done = 1'b1; tick(); done = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (cmd_start) ns++; end
    checks++;
    if (ns != 0 || cmd_out !== 24'hF00002) begin errors++; $display("FAIL flush_done_ignored starts=%0d out=%h", ns, cmd_out); end
    wr_en = 1'b1; wr_data = 24'h500000; tick(); wr_en = 1'b0;
    tick();
    checks++;
    if (cmd_start !== 1'b1 || cmd_out !== 24'h500000) begin
      errors++; $display("FAIL flush_next start=%b out=%h exp 1/500000", cmd_start, cmd_out);
    end
    checks++;
    if (dvec !== mvec()) begin errors++; $display("FAIL flush_model t=%0d got=%h exp=%h", t, dvec, mvec()); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      wr_en     = ($urandom_range(1, 0) == 1);
      wr_data   = 24'($urandom);
      if ($urandom_range(7, 0) == 0) wr_data[23:20] = 4'hF;
      else if (wr_data[23:20] == 4'hF) wr_data[23:20] = 4'h1;
      done      = ($urandom_range(19, 0) == 0);
      frame     = ($urandom_range(29, 0) == 0);
      flush     = ($urandom_range(99, 0) == 0);
      clr_flags = ($urandom_range(49, 0) == 0);
      if ($urandom_range(199, 0) == 0) sync_mode = ~sync_mode;
      tick();
      checks++;
      if (dvec !== mvec()) begin
        errors++;
        if (bad < 10) $display("FAIL random t=%0d got=%h exp=%h", t, dvec, mvec());
        bad++;
      end
    end
    {wr_en, done, frame, flush, clr_flags, sync_mode} = '0;
  endtask

  initial begin
    test_reset();
    test_spacing();
    test_blocking();
    test_full();
    test_frame();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
